// File: rtl/cla4_serial_adder.sv
// Sequential WIDTH-bit adder: one 4-bit carry-lookahead slice reused LSB→MSB, one nibble per clock.
// The inter-nibble carry rides in a flop; the sum builds up in place and is qualified by done.
module cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] sum,
    output logic       co
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g    = a & b;
    assign p    = a ^ b;
    assign c[0] = ci;
    assign c[1] = g[0] | (p[0] & ci);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & ci);
    assign sum  = p ^ c[3:0];
    assign co   = c[4];
endmodule

module cla4_serial_adder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ov
);
    localparam int N  = WIDTH / 4;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic [CW-1:0]    count;
    logic             carry;
    logic [3:0]       nib_a, nib_b, nib_sum;
    logic             nib_co;
    logic             last;

    assign last = (count == LAST);

    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int k = 0; k < N; k++) begin
            if (int'(count) == k) begin
                nib_a = a_reg[4*k +: 4];
                nib_b = b_reg[4*k +: 4];
            end
        end
    end

    cla4 u_cla4 (
        .a   (nib_a),
        .b   (nib_b),
        .ci  (carry),
        .sum (nib_sum),
        .co  (nib_co)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg <= '0;
            b_reg <= '0;
            carry <= 1'b0;
            count <= '0;
            s     <= '0;
            co    <= 1'b0;
            ov    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_reg <= a;
                    b_reg <= b;
                    carry <= ci;
                    count <= '0;
                    s     <= '0;
                    co    <= 1'b0;
                    ov    <= 1'b0;
                end
                RUN: begin
                    for (int k = 0; k < N; k++)
                        if (int'(count) == k) s[4*k +: 4] <= nib_sum;
                    carry <= nib_co;
                    if (last) begin
                        // count parks at 0 so it never steps past N-1
                        count <= '0;
                        co    <= nib_co;
                        ov    <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (nib_sum[3] != a_reg[WIDTH-1]);
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);
endmodule

// File: tb/tb_cla4_serial_adder.sv
// Directed bench for cla4_serial_adder: 32-bit instance with a result scoreboard, plus a 4-bit instance.
module tb_cla4_serial_adder;
    logic        clk = 1'b0;
    logic        reset;
    logic        start, ci, busy, done, co, ov;
    logic [31:0] a, b, s;
    logic        start4, ci4, busy4, done4, co4, ov4;
    logic [3:0]  a4, b4, s4;

    always #5 clk = ~clk;

    cla4_serial_adder #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .ci(ci),
        .busy(busy), .done(done), .s(s), .co(co), .ov(ov)
    );

    cla4_serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .a(a4), .b(b4), .ci(ci4),
        .busy(busy4), .done(done4), .s(s4), .co(co4), .ov(ov4)
    );

    typedef struct packed {
        logic [31:0] s;
        logic        co;
        logic        ov;
    } res_t;

    res_t sb[$];
    res_t exp_r;
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic res_t model(input logic [31:0] x, input logic [31:0] y, input logic c);
        logic [32:0] t;
        res_t r;
        t    = {1'b0, x} + {1'b0, y} + 33'(c);
        r.s  = t[31:0];
        r.co = t[32];
        r.ov = (x[31] == y[31]) && (t[31] != x[31]);
        return r;
    endfunction

    // Scoreboard: every done pulse retires the oldest expected result
    always @(negedge clk) begin
        if (reset === 1'b0 && done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'(sb.size()), 64'd1);
            end else begin
                exp_r = sb.pop_front();
                chk("sum", 64'(s), 64'(exp_r.s));
                chk("co",  64'(co), 64'(exp_r.co));
                chk("ov",  64'(ov), 64'(exp_r.ov));
            end
        end
    end

    // Returns at the negedge following the accepting edge E0
    task automatic start_op(input logic [31:0] x, input logic [31:0] y, input logic c);
        @(negedge clk);
        a = x; b = y; ci = c; start = 1'b1;
        sb.push_back(model(x, y, c));
        @(negedge clk);
        start = 1'b0;
        a = $urandom; b = $urandom; ci = 1'b0;
    endtask

    // Counts negedges (busy ones separately) until done, bounded
    task automatic wait_done(input string tag, input int lat);
        int  cyc    = 0;
        int  busy_n = 0;
        bit  seen   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (busy === 1'b1) busy_n++;
            cyc++;
            @(negedge clk);
        end
        chk({tag, "_done_seen"}, 64'(seen), 64'd1);
        chk({tag, "_latency"}, 64'(cyc), 64'(lat));
        chk({tag, "_busy_cycles"}, 64'(busy_n), 64'(lat));
    endtask

    task automatic op4(input logic [3:0] x, input logic [3:0] y, input logic c);
        logic [4:0] t;
        t = {1'b0, x} + {1'b0, y} + 5'(c);
        @(negedge clk);
        a4 = x; b4 = y; ci4 = c; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        chk("w4_busy", 64'(busy4), 64'd1);
        @(negedge clk);
        chk("w4_done", 64'(done4), 64'd1);
        chk("w4_sum", 64'(s4), 64'(t[3:0]));
        chk("w4_co", 64'(co4), 64'(t[4]));
        chk("w4_ov", 64'(ov4), 64'((x[3] == y[3]) && (t[3] != x[3])));
        @(negedge clk);
        chk("w4_done_single", 64'(done4), 64'd0);
    endtask

    int d_at[$];

    initial begin
        reset = 1'b1; start = 1'b0; a = '0; b = '0; ci = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; ci4 = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_s", 64'(s), 64'd0);
        chk("rst_co_ov", 64'({co, ov}), 64'd0);
        reset = 1'b0;

        start_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0); wait_done("t1", 8);
        start_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0); wait_done("t2a", 8);
        start_op(32'h8000_0000, 32'h8000_0000, 1'b0); wait_done("t2b", 8);
        start_op(32'h0000_0000, 32'h0000_0000, 1'b1); wait_done("t3a", 8);
        start_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0); wait_done("t3b", 8);
        for (int i = 0; i < 4; i++) begin
            start_op($urandom, $urandom, 1'($urandom_range(0, 1)));
            wait_done("rand", 8);
        end

        // start re-asserted at E0+3 with new operands must be ignored
        start_op(32'h1, 32'h1, 1'b0);
        repeat (2) @(negedge clk);
        a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
        wait_done("t4", 6);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("t4_no_second_op", 64'(busy), 64'd0);
        chk("t4_sb_empty", 64'(sb.size()), 64'd0);

        // Reset at E0+3 aborts the operation
        start_op(32'h1234_5678, 32'h1, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_done", 64'(done), 64'd0);
        chk("t5_s", 64'(s), 64'd0);
        chk("t5_co", 64'(co), 64'd0);
        sb.delete();
        reset = 1'b0;
        start_op(32'hDEAD_BEEF, 32'h2152_4111, 1'b1); wait_done("t5_after", 8);

        // start held high for 30 cycles
        for (int i = 0; i < 3; i++) sb.push_back(model(32'h0F0F_0F0F, 32'h1111_1111, 1'b0));
        @(negedge clk);
        a = 32'h0F0F_0F0F; b = 32'h1111_1111; ci = 1'b0; start = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (done === 1'b1) d_at.push_back(i);
        end
        start = 1'b0;
        chk("t6_pulses", 64'(d_at.size()), 64'd3);
        if (d_at.size() == 3) begin
            chk("t6_first", 64'(d_at[0]), 64'd9);
            chk("t6_gap1", 64'(d_at[1] - d_at[0]), 64'd10);
            chk("t6_gap2", 64'(d_at[2] - d_at[1]), 64'd10);
        end
        repeat (2) @(negedge clk);
        chk("t6_sb_empty", 64'(sb.size()), 64'd0);

        op4(4'hF, 4'h1, 1'b0);
        op4(4'h7, 4'h1, 1'b0);
        op4(4'h8, 4'h8, 1'b0);
        op4(4'h5, 4'h9, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
